// File: rtl/arb_pkg.sv
// Shared arbitration definitions: capture FSM state encodings and index-width helper.
package arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Index width for an n-line one-hot vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grant_payload_capture_onehot_enc.sv
// Combinational one-hot to index encoder with any-bit and multi-hot flags.
module onehot_enc
  import arb_pkg::*;
#(
  parameter int unsigned N  = 7,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        multi = multi | any;
        any   = 1'b1;
        idx   = idx | IW'(i);
      end
    end
  end

endmodule

// File: rtl/grant_payload_capture.sv
// Captures the arbiter winner's payload and presents it on valid/ready, acking the owner.
// Optional stall timeout in HOLD is enabled by defining OUT_TIMEOUT_EN.
module grant_payload_capture
  import arb_pkg::*;
#(
  parameter int unsigned N       = 7,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         grant,
  input  logic [N*W-1:0]       req_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [idx_w(N)-1:0]  out_src,
  output logic [N-1:0]         ack,
  output logic                 grant_err,
  output logic                 timeout
);

  localparam int unsigned IW = idx_w(N);

  logic [0:0]    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [IW-1:0] out_src_q, out_src_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          grant_err_q, grant_err_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] g_idx;
  logic          g_any, g_multi;
  logic [W-1:0]  cap_data;

  onehot_enc #(.N(N), .IW(IW)) u_enc (
    .vec   (grant),
    .idx   (g_idx),
    .any   (g_any),
    .multi (g_multi)
  );

  always_comb begin
    cap_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (g_idx == IW'(i)) cap_data = req_data[i*W +: W];
    end
  end

`ifdef OUT_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ack_d       = '0;
    grant_err_d = grant_err_q;
    timeout_d   = 1'b0;
`ifdef OUT_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (g_multi) begin
          grant_err_d = 1'b1;
        end else if (g_any) begin
          out_data_d  = cap_data;
          out_src_d   = g_idx;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
`ifdef OUT_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      default: begin
        if (out_ready) begin
          for (int unsigned i = 0; i < N; i++) ack_d[i] = (out_src_q == IW'(i));
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
`ifdef OUT_TIMEOUT_EN
        // Handshake takes priority over a drop in the cycle the count hits TIMEOUT.
        else if (stall_cnt_q == CW'(TIMEOUT)) begin
          out_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ack_q       <= '0;
      grant_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ack_q       <= ack_d;
      grant_err_q <= grant_err_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef OUT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign ack       = ack_q;
  assign grant_err = grant_err_q;

endmodule
